fetch: RTL and testbench

Instruction-fetch stage that drives the decode stage's `instr_raw`/`pc_in` inputs. It owns the PC and reads a synchronous instruction memory. It honours decode's `stall`, redirects on `branch_wrong`, pre-decodes JAL/JALR, and injects NOPs whenever no valid instruction is available. Decode has no valid input, so a bubble is always presented as `addi x0,x0,0`.

---
 rtl/fetch.sv | 109 ++++++++++
 tb/tb_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, reads a synchronous instruction memory,
// pre-decodes JAL/JALR and presents a NOP on instr_raw whenever no word is live.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_wrong,
  input  logic [31:0] branch_target,
  input  logic        jalr_valid,
  input  logic [31:0] jalr_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_raw,
  output logic [31:0] pc_out,
  output logic [31:0] bubble_count
);

  typedef enum logic {
    RUN,
    JALR_WAIT
  } state_t;

  localparam logic [6:0]  OPC_JAL   = 7'b1101111;
  localparam logic [6:0]  OPC_JALR  = 7'b1100111;
  localparam logic [31:0] ALIGN_MSK = 32'hFFFF_FFFC;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] bubble_q;
  logic        v_q, v_d;
  logic        running;
  logic        jal_hit, jalr_hit, redirect;
  logic [31:0] jal_imm, jal_target;

  // A stalled cycle keeps imem_en low, so the memory output (and instr_raw) stays put.
  assign instr_raw    = v_q ? imem_rdata : NOP;
  assign pc_out       = fpc_q;
  assign imem_addr    = pc_q;
  assign bubble_count = bubble_q;

  assign running  = (state == RUN);
  assign jal_hit  = running & v_q & ~stall & (instr_raw[6:0] == OPC_JAL);
  assign jalr_hit = running & v_q & ~stall & (instr_raw[6:0] == OPC_JALR)
                    & (instr_raw[14:12] == 3'b000);

  assign jal_imm    = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12],
                       instr_raw[20], instr_raw[30:21], 1'b0};
  assign jal_target = fpc_q + jal_imm;

  assign redirect = branch_wrong | ((state == JALR_WAIT) & jalr_valid) | jal_hit;
  assign imem_en  = ~rst & ((running & ~stall) | redirect);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    pc_d       = pc_q;
    fpc_d      = fpc_q;
    v_d        = v_q;
    state_next = state;
    if (branch_wrong) begin
      pc_d       = branch_target & ALIGN_MSK;
      v_d        = 1'b0;
      state_next = RUN;
    end else if (stall) begin
      // hold everything
    end else if (state == JALR_WAIT) begin
      v_d = 1'b0;
      if (jalr_valid) begin
        pc_d       = jalr_target & ALIGN_MSK;
        state_next = RUN;
      end
    end else if (jal_hit) begin
      // The sequential word already in flight is squashed by clearing v.
      pc_d = jal_target & ALIGN_MSK;
      v_d  = 1'b0;
    end else if (jalr_hit) begin
      v_d        = 1'b0;
      state_next = JALR_WAIT;
    end else begin
      fpc_d = pc_q;
      pc_d  = pc_q + 32'd4;
      v_d   = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      fpc_q    <= '0;
      v_q      <= 1'b0;
      state    <= RUN;
      bubble_q <= '0;
    end else begin
      pc_q  <= pc_d;
      fpc_q <= fpc_d;
      v_q   <= v_d;
      state <= state_next;
      if (~stall & ~v_q) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios from the feature list plus a
// randomized stall/branch/reset run checked against an architectural-stream model.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst, stall, branch_wrong, jalr_valid, imem_en;
  logic [31:0] branch_target, jalr_target, imem_addr, imem_rdata;
  logic [31:0] instr_raw, pc_out, bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog [logic [31:0]];

  fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_wrong (branch_wrong),
    .branch_target(branch_target),
    .jalr_valid   (jalr_valid),
    .jalr_target  (jalr_target),
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .imem_rdata   (imem_rdata),
    .instr_raw    (instr_raw),
    .pc_out       (pc_out),
    .bubble_count (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: explicit words, else an addi with rd=1 tagged by the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return {a[19:0], 5'd1, 7'h13};
  endfunction

  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; branch_wrong = 1'b0; jalr_valid = 1'b0;
    branch_target = '0; jalr_target = '0;
    tick();
    tick();
    n_checks++;
    if (instr_raw !== NOP || pc_out !== 32'h0 || imem_addr !== 32'h0 ||
        imem_en !== 1'b0 || bubble_count !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: instr=%h pc=%h addr=%h en=%b bub=%0d, want %h 0 0 0 0",
               instr_raw, pc_out, imem_addr, imem_en, bubble_count, NOP);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ei [3];
    logic [31:0] ep [3];
    prog.delete();
    prog[0] = 32'h0000_0093; prog[4] = 32'h0010_0113; prog[8] = 32'h0020_0193;
    ei = '{32'h0000_0093, 32'h0010_0113, 32'h0020_0193};
    ep = '{32'h0, 32'h4, 32'h8};
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (instr_raw !== ei[i] || pc_out !== ep[i]) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: got %h@%h, want %h@%h", i, instr_raw, pc_out, ei[i], ep[i]);
      end
    end
    n_checks++;
    if (bubble_count !== 32'd1) begin
      n_fail++;
      $display("FAIL reset_bubbles: got %0d, want 1", bubble_count);
    end
  endtask

  task automatic test_stall();
    reset_dut();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (instr_raw !== mem_word(32'h4) || pc_out !== 32'h4 || imem_en !== 1'b0 ||
          bubble_count !== 32'd1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h@%h en=%b bub=%0d, want %h@4 en=0 bub=1",
                 i, instr_raw, pc_out, imem_en, bubble_count, mem_word(32'h4));
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (instr_raw !== mem_word(32'h8) || pc_out !== 32'h8 || bubble_count !== 32'd1) begin
      n_fail++;
      $display("FAIL stall_resume: got %h@%h bub=%0d, want %h@8 bub=1",
               instr_raw, pc_out, bubble_count, mem_word(32'h8));
    end
  endtask

  task automatic test_jal();
    logic [31:0] ei [5];
    logic [31:0] ep [5];
    prog.delete();
    prog[8]  = 32'h0100_006F;  // jal x0, +16
    prog[24] = 32'hFF1F_F06F;  // jal x0, -16
    ei = '{32'h0100_006F, NOP, 32'hFF1F_F06F, NOP, 32'h0100_006F};
    ep = '{32'd8, 32'd0, 32'd24, 32'd0, 32'd8};
    reset_dut();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (instr_raw !== ei[i] || (ei[i] != NOP && pc_out !== ep[i])) begin
        n_fail++;
        $display("FAIL jal_seq[%0d]: got %h@%h, want %h@%h", i, instr_raw, pc_out, ei[i], ep[i]);
      end
    end
    n_checks++;
    if (bubble_count !== 32'd3) begin
      n_fail++;
      $display("FAIL jal_bubbles: got %0d, want 3", bubble_count);
    end
  endtask

  task automatic test_jalr();
    int w;
    w = $urandom_range(1, 4);
    prog.delete();
    prog[12] = 32'h0000_80E7;  // jalr x1, 0(x1)
    reset_dut();
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (instr_raw !== 32'h0000_80E7 || pc_out !== 32'd12) begin
      n_fail++;
      $display("FAIL jalr_present: got %h@%h, want 000080e7@c", instr_raw, pc_out);
    end
    for (int i = 0; i < w; i++) begin
      tick();
      n_checks++;
      if (instr_raw !== NOP || imem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL jalr_wait[%0d]: got %h en=%b, want %h en=0", i, instr_raw, imem_en, NOP);
      end
    end
    jalr_valid = 1'b1;
    jalr_target = 32'h0000_0042;
    #1;
    n_checks++;
    if (imem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr_en: got %b, want 1", imem_en);
    end
    tick();
    jalr_valid = 1'b0;
    n_checks++;
    if (instr_raw !== NOP) begin
      n_fail++;
      $display("FAIL jalr_tail_nop: got %h, want %h", instr_raw, NOP);
    end
    tick();
    n_checks++;
    if (instr_raw !== mem_word(32'h40) || pc_out !== 32'h40 || bubble_count !== 32'(w + 2)) begin
      n_fail++;
      $display("FAIL jalr_target: got %h@%h bub=%0d, want %h@40 bub=%0d",
               instr_raw, pc_out, bubble_count, mem_word(32'h40), w + 2);
    end
  endtask

  task automatic test_branch_over_stall();
    prog.delete();
    reset_dut();
    tick();
    tick();
    tick();
    stall = 1'b1;
    branch_wrong = 1'b1;
    branch_target = 32'h0000_0080;
    #1;
    n_checks++;
    if (imem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_en: got %b, want 1", imem_en);
    end
    tick();
    stall = 1'b0;
    branch_wrong = 1'b0;
    n_checks++;
    if (instr_raw !== NOP || bubble_count !== 32'd1) begin
      n_fail++;
      $display("FAIL branch_nop: got %h bub=%0d, want %h bub=1", instr_raw, bubble_count, NOP);
    end
    tick();
    n_checks++;
    if (instr_raw !== mem_word(32'h80) || pc_out !== 32'h80 || bubble_count !== 32'd2) begin
      n_fail++;
      $display("FAIL branch_target: got %h@%h bub=%0d, want %h@80 bub=2",
               instr_raw, pc_out, bubble_count, mem_word(32'h80));
    end
  endtask

  task automatic test_reset_in_jalr_wait();
    prog.delete();
    prog[12] = 32'h0000_80E7;
    reset_dut();
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    jalr_valid = 1'b1;
    jalr_target = 32'h0000_0040;
    n_checks++;
    if (instr_raw !== NOP || pc_out !== 32'h0 || imem_addr !== 32'h0 || bubble_count !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_jalr_state: got %h@%h addr=%h bub=%0d, want %h@0 addr=0 bub=0",
               instr_raw, pc_out, imem_addr, bubble_count, NOP);
    end
    tick();
    jalr_valid = 1'b0;
    tick();
    n_checks++;
    if (instr_raw !== mem_word(32'h4) || pc_out !== 32'h4 || bubble_count !== 32'd1) begin
      n_fail++;
      $display("FAIL rst_jalr_restart: got %h@%h bub=%0d, want %h@4 bub=1",
               instr_raw, pc_out, bubble_count, mem_word(32'h4));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ep [3];
    ep = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    prog.delete();
    reset_dut();
    branch_wrong = 1'b1;
    branch_target = 32'hFFFF_FFFB;
    tick();
    branch_wrong = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (instr_raw !== mem_word(ep[i]) || pc_out !== ep[i]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h@%h, want %h@%h", i, instr_raw, pc_out, mem_word(ep[i]), ep[i]);
      end
    end
  endtask

  // Model: decode sees a stream of words from next_m onward; a redirect inserts
  // exactly one presented NOP, a stall freezes the view, and NOPs seen unstalled count.
  task automatic test_random();
    logic        valid_m;
    logic [31:0] pc_m, next_m, exp_instr;
    int unsigned bub_m;
    prog.delete();
    reset_dut();
    valid_m = 1'b0; pc_m = '0; next_m = '0; bub_m = 0;
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 99) < 30);
      branch_wrong  = ($urandom_range(0, 99) < 6);
      branch_target = $urandom_range(0, 32'h3FF);
      jalr_valid    = $urandom_range(0, 1);
      jalr_target   = $urandom;
      if (rst) begin
        valid_m = 1'b0; pc_m = '0; next_m = '0; bub_m = 0;
      end else begin
        if (!stall && !valid_m) bub_m++;
        if (branch_wrong) begin
          valid_m = 1'b0;
          next_m  = {branch_target[31:2], 2'b00};
        end else if (!stall) begin
          valid_m = 1'b1;
          pc_m    = next_m;
          next_m  = next_m + 32'd4;
        end
      end
      tick();
      exp_instr = valid_m ? mem_word(pc_m) : NOP;
      n_checks++;
      if (instr_raw !== exp_instr || (valid_m && pc_out !== pc_m) || bubble_count !== bub_m) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h@%h bub=%0d, want %h@%h bub=%0d",
                 c, instr_raw, pc_out, bubble_count, exp_instr, pc_m, bub_m);
      end
    end
    rst = 1'b0; stall = 1'b0; branch_wrong = 1'b0; jalr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall();
    test_jal();
    test_jalr();
    test_branch_over_stall();
    test_reset_in_jalr_wait();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
